// File: rtl/coax_tx_buffer.sv
// coax_tx_buffer: word FIFO feeding the coax serializer, with commit/start handshake
// and sticky overflow/underflow flags.
module coax_tx_buffer #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_strobe,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    commit,
    input  logic                    flush,
    input  logic                    err_clear,
    input  logic                    tx_active,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    tx_last,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    pending,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_START} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  pop, push;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign count     = count_q;
    assign full      = count_q == CW'(DEPTH);
    assign tx_valid  = count_q != '0;
    assign tx_last   = count_q == CW'(1);
    assign tx_data   = mem_q[rd_ptr_q];
    assign tx_start  = state_q == ST_START;
    assign pending   = state_q == ST_WAIT;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        pop         = tx_ready && tx_valid;
        push        = wr_strobe && (!full || pop);
        wr_ptr_d    = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(pop);
        // a fresh error in the same cycle as err_clear keeps the flag set
        overflow_d  = (wr_strobe && full && !pop) || (overflow_q && !err_clear);
        underflow_d = (tx_ready && !tx_valid) || (underflow_q && !err_clear);
        state_d     = state_q;
        case (state_q)
            ST_IDLE:  state_d = (commit && tx_valid) ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_d = !tx_valid ? ST_IDLE : !tx_active ? ST_START : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // storage needs no reset; head content is don't-care while empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_coax_tx_buffer.sv
// tb_coax_tx_buffer: directed + random stimulus against a queue-based reference model.
module tb_coax_tx_buffer;
    localparam int DW = 10;
    localparam int DEPTH = 16;

    logic clk = 0, reset_n = 0;
    logic wr_strobe = 0, commit = 0, flush = 0, err_clear = 0, tx_active = 0, tx_ready = 0;
    logic [DW-1:0] wr_data = '0;
    logic tx_start, tx_valid, tx_last, full, pending, overflow, underflow;
    logic [DW-1:0] tx_data;
    logic [4:0] count;

    int n_cmp = 0, n_err = 0;

    // reference model: queue of words plus commit bookkeeping
    logic [DW-1:0] q[$];
    bit m_pend, m_start, m_ovf, m_unf;

    coax_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .commit(commit), .flush(flush), .err_clear(err_clear), .tx_active(tx_active),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .count(count), .full(full), .pending(pending),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_start = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step();
        int sz = q.size();
        bit pop = tx_ready && sz > 0;
        bit pushed = wr_strobe && (sz < DEPTH || pop);
        m_ovf = (wr_strobe && sz == DEPTH && !pop) || (m_ovf && !err_clear);
        m_unf = (tx_ready && sz == 0) || (m_unf && !err_clear);
        if (flush) begin
            q.delete(); m_pend = 0; m_start = 0;
            return;
        end
        if (m_start) m_start = 0;
        else if (m_pend) begin
            if (sz == 0) m_pend = 0;
            else if (!tx_active) begin m_pend = 0; m_start = 1; end
        end else if (commit && sz > 0) m_pend = 1;
        if (pop) void'(q.pop_front());
        if (pushed) q.push_back(wr_data);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(tx_valid), 32'(q.size() > 0));
        chk({tag, ".last"}, 32'(tx_last), 32'(q.size() == 1));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".start"}, 32'(tx_start), 32'(m_start));
        chk({tag, ".pending"}, 32'(pending), 32'(m_pend));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        if (q.size() > 0) chk({tag, ".data"}, 32'(tx_data), 32'(q[0]));
    endtask

    task automatic cyc(input string tag, input bit wr, input logic [DW-1:0] wd,
                       input bit cm, input bit fl, input bit ec, input bit act, input bit rdy);
        wr_strobe = wr; wr_data = wd; commit = cm; flush = fl;
        err_clear = ec; tx_active = act; tx_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, '0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1;
        idle("post_reset", 1);

        // three words, commit, start two cycles later, pop in order
        cyc("push", 1, 10'h005, 0, 0, 0, 0, 0);
        cyc("push", 1, 10'h2A5, 0, 0, 0, 0, 0);
        cyc("push", 1, 10'h3FF, 0, 0, 0, 0, 0);
        cyc("commit", 0, '0, 1, 0, 0, 0, 0);
        chk("lat1.start", 32'(tx_start), 0);
        idle("lat", 1);
        chk("lat2.start", 32'(tx_start), 1);
        chk("lat2.head", 32'(tx_data), 32'h005);
        idle("after_start", 1);
        chk("pulse.start", 32'(tx_start), 0);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);
        chk("pop1.head", 32'(tx_data), 32'h2A5);
        chk("pop1.last", 32'(tx_last), 0);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);
        chk("pop2.head", 32'(tx_data), 32'h3FF);
        chk("pop2.last", 32'(tx_last), 1);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);
        chk("drained.valid", 32'(tx_valid), 0);

        // overflow, then push+pop while full
        for (int i = 0; i < DEPTH + 1; i++) cyc("fill", 1, 10'($urandom), 0, 0, 0, 0, 0);
        chk("ovf.count", 32'(count), 16);
        chk("ovf.flag", 32'(overflow), 1);
        cyc("full_pushpop", 1, 10'h155, 0, 0, 0, 0, 1);
        chk("pp.count", 32'(count), 16);
        for (int i = 0; i < DEPTH; i++) cyc("drain", 0, '0, 0, 0, 0, 0, 1);
        cyc("ovf_clr", 0, '0, 0, 0, 1, 0, 0);
        chk("ovf.cleared", 32'(overflow), 0);

        // commit while serializer busy
        cyc("push", 1, 10'h0AA, 0, 0, 0, 1, 0);
        cyc("push", 1, 10'h0BB, 0, 0, 0, 1, 0);
        cyc("commit_busy", 0, '0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("busy", 0, '0, 0, 0, 0, 1, 0);
        chk("busy.pending", 32'(pending), 1);
        chk("busy.start", 32'(tx_start), 0);
        idle("released", 1);
        chk("rel.start", 32'(tx_start), 1);
        chk("rel.pending", 32'(pending), 0);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);

        // empty commit, underflow, err_clear
        cyc("commit_empty", 0, '0, 1, 0, 0, 0, 0);
        idle("empty", 2);
        chk("empty.pending", 32'(pending), 0);
        cyc("unf", 0, '0, 0, 0, 0, 0, 1);
        chk("unf.flag", 32'(underflow), 1);
        cyc("unf_keep", 0, '0, 0, 0, 1, 0, 1);
        chk("unf.kept", 32'(underflow), 1);
        cyc("unf_clr", 0, '0, 0, 0, 1, 0, 0);
        chk("unf.cleared", 32'(underflow), 0);

        // flush beats push, commit and pending start
        for (int i = 0; i < 4; i++) cyc("push4", 1, 10'($urandom), 0, 0, 0, 0, 0);
        cyc("commit", 0, '0, 1, 0, 0, 0, 0);
        cyc("flush", 1, 10'h111, 0, 1, 0, 0, 0);
        chk("flush.count", 32'(count), 0);
        chk("flush.pending", 32'(pending), 0);
        idle("post_flush", 2);

        // asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) cyc("push6", 1, 10'($urandom), 0, 0, 0, 0, 0);
        cyc("commit", 0, '0, 1, 0, 0, 0, 0);
        idle("frame", 2);
        cyc("pop", 0, '0, 0, 0, 0, 1, 1);
        chk("prerst.count", 32'(count), 5);
        #2 reset_n = 0;
        #1;
        chk("arst.count", 32'(count), 0);
        chk("arst.valid", 32'(tx_valid), 0);
        chk("arst.last", 32'(tx_last), 0);
        chk("arst.pending", 32'(pending), 0);
        chk("arst.start", 32'(tx_start), 0);
        model_reset();
        @(negedge clk) reset_n = 1;
        idle("post_arst", 1);

        // pointer wrap over three fill/drain passes
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) cyc("wrap_fill", 1, 10'($urandom), 0, 0, 0, 0, 0);
            for (int i = 0; i < DEPTH; i++) cyc("wrap_drain", 0, '0, 0, 0, 0, 0, 1);
        end

        // random traffic
        for (int i = 0; i < 1500; i++)
            cyc("rand", $urandom_range(0, 99) < 55, 10'($urandom), $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
